// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts a MemRead/MemWrite request, waits WAIT_CYCLES, then completes with a one-cycle MemReady.
// Optional feature macro: MEM_RANGE_CHECK_EN (flags and suppresses accesses above the RAM size).
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemReady,
  output logic                  MemBusy,
  output logic                  MemErr
);

  // state  | meaning
  // S_IDLE | waiting for a request; operands latched on accept
  // S_WAIT | counting wait states down to 1
  // S_RESP | access done on entry edge; MemReady high for this cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    req;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_oor;
  logic                    commit;
  logic                    com_wr;
  logic [DEPTH_LOG2-1:0]   com_idx;
  logic [DATA_WIDTH-1:0]   com_wdata;
  logic                    com_err;
  logic                    mem_we;

  assign req     = MemRead | MemWrite;
  assign req_idx = Address[DEPTH_LOG2+1:2];

`ifdef MEM_RANGE_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];
  assign req_oor          = |Address[ADDR_WIDTH-1:DEPTH_LOG2+2];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Address[ADDR_WIDTH-1:DEPTH_LOG2+2], Address[1:0]};
  assign req_oor          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    commit    = 1'b0;
    com_wr    = wr_q;
    com_idx   = idx_q;
    com_wdata = wdata_q;
    com_err   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = MemWrite;
          idx_d   = req_idx;
          wdata_d = WriteData;
          err_d   = req_oor;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            // With no wait states the accept edge is also the RESP entry edge,
            // so the access must use the live request operands.
            state_d   = S_RESP;
            commit    = 1'b1;
            com_wr    = MemWrite;
            com_idx   = req_idx;
            com_wdata = WriteData;
            com_err   = req_oor;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit && !com_wr) begin
      rdata_d = com_err ? '0 : mem_q[com_idx];
    end
  end

  assign mem_we = commit & com_wr & ~com_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; only the commit is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[com_idx] <= com_wdata;
    end
  end

  assign MemData  = rdata_q;
  assign MemReady = (state_q == S_RESP);
  assign MemBusy  = (state_q != S_IDLE);

`ifdef MEM_RANGE_CHECK_EN
  assign MemErr = MemReady & err_q;
`else
  assign MemErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with 2 wait states, one with none,
// each checked against a word-array memory model and latency rules.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] md   [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        err  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mmem     [2][256];
  bit          mval     [2][256];
  logic [31:0] last_md  [2];
  bit          md_known [2];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .MemRead(rd[0]), .MemWrite(wr[0]), .Address(addr[0]),
    .WriteData(wd[0]), .MemData(md[0]), .MemReady(rdy[0]), .MemBusy(busy[0]), .MemErr(err[0])
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .MemRead(rd[1]), .MemWrite(wr[1]), .Address(addr[1]),
    .WriteData(wd[1]), .MemData(md[1]), .MemReady(rdy[1]), .MemBusy(busy[1]), .MemErr(err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return (a >> 10) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete request/response handshake on instance d, checked against the model.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] data, input bit scramble, input string tag);
    int          wc;
    int          idx;
    int          cyc;
    bit          got;
    bit          e;
    bit          chk_md;
    logic [31:0] exp_md;
    wc  = wait_of(d);
    idx = int'(a[9:2]);
    e   = out_of_range(a);
    if (w) begin
      if (!e) begin
        mmem[d][idx] = data;
        mval[d][idx] = 1'b1;
      end
      exp_md = last_md[d];
      chk_md = md_known[d];
    end else begin
      exp_md = e ? 32'h0 : mmem[d][idx];
      chk_md = e || mval[d][idx];
      last_md[d]  = exp_md;
      md_known[d] = chk_md;
    end

    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = data;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc == 1) begin
        addr[d] = $urandom;
        wd[d]   = $urandom;
      end
      if (rdy[d]) begin
        got = 1'b1;
      end else begin
        tests_run++;
        if (busy[d] !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy_wait: got %b expected 1 (cycle %0d)", tag, busy[d], cyc);
        end
      end
    end
    tests_run++;
    if (!got || cyc != wc + 1) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles (ready=%b) expected %0d", tag, cyc, got, wc + 1);
    end
    if (got) begin
      tests_run++;
      if (busy[d] !== 1'b1 || err[d] !== e) begin
        tests_failed++;
        $display("FAIL %s resp_flags: got busy=%b err=%b expected busy=1 err=%b", tag, busy[d], err[d], e);
      end
      if (chk_md) begin
        tests_run++;
        if (md[d] !== exp_md) begin
          tests_failed++;
          $display("FAIL %s memdata: got %h expected %h", tag, md[d], exp_md);
        end
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (rdy[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_resp: got rdy=%b busy=%b err=%b expected 0 0 0", tag, rdy[d], busy[d], err[d]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (md[d] !== 32'h0 || rdy[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s inst%0d: got md=%h rdy=%b busy=%b err=%b expected all zero",
                 tag, d, md[d], rdy[d], busy[d], err[d]);
      end
      last_md[d]  = 32'h0;
      md_known[d] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "w2_write_10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "w2_read_10");
    access(1, 1'b0, 1'b1, 32'h04, 32'hCAFEF00D, 1'b0, "w0_write_04");
    access(1, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, "w0_read_04");
  endtask

  task automatic test_both_high();
    access(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, "both_high");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "both_high_readback");
  endtask

  // Request held continuously: one MemReady per accept, period WAIT_CYCLES+2.
  task automatic test_back_to_back(input int d, input logic [31:0] a);
    int p;
    bit exp_rdy;
    p = wait_of(d) + 2;
    @(negedge clk);
    rd[d] = 1'b1; addr[d] = a;
    for (int k = 1; k <= 4 * p; k++) begin
      @(posedge clk);
      #1;
      exp_rdy = (k % p) == (p - 1);
      tests_run++;
      if (rdy[d] !== exp_rdy || (exp_rdy && md[d] !== mmem[d][int'(a[9:2])])) begin
        tests_failed++;
        $display("FAIL b2b inst%0d cycle %0d: got rdy=%b md=%h expected rdy=%b md=%h",
                 d, k, rdy[d], md[d], exp_rdy, mmem[d][int'(a[9:2])]);
      end
    end
    rd[d] = 1'b0;
    last_md[d]  = mmem[d][int'(a[9:2])];
    md_known[d] = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_release inst%0d: got busy=%b expected 0", d, busy[d]);
    end
  endtask

  task automatic test_scramble();
    access(0, 1'b0, 1'b1, 32'h28, 32'h0BADC0DE, 1'b1, "scramble_write");
    access(0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b1, "scramble_read");
  endtask

  task automatic test_reset_mid();
    access(0, 1'b0, 1'b1, 32'h30, 32'hA5A50001, 1'b0, "mid_old_write");
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h30; wd[0] = 32'hFFFF0BAD;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_accept: got busy=%b expected 1", busy[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    wr[0] = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "mid_readback");
  endtask

  task automatic test_range();
    access(0, 1'b0, 1'b1, 32'h000, 32'h11111111, 1'b0, "range_w0");
    access(0, 1'b0, 1'b1, 32'h400, 32'h22222222, 1'b0, "range_w400");
    access(0, 1'b1, 1'b0, 32'h000, 32'h0, 1'b0, "range_r0");
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "range_r400");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          r;
    bit          w;
    int          sel;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, "rand_fill");
      end
      for (int i = 0; i < 30; i++) begin
        a = {28'h0, 4'($urandom_range(0, 15))} << 2;
        a[1:0] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[31:10] = 22'($urandom_range(1, 4095));
        sel = $urandom_range(0, 4);
        r = (sel != 0);
        w = (sel == 0) || (sel == 4);
        access(d, r, w, a, $urandom, 1'($urandom_range(0, 1)), "rand_op");
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wd[d] = 32'h0;
      last_md[d] = 32'h0; md_known[d] = 1'b0;
      for (int i = 0; i < 256; i++) begin
        mmem[d][i] = 32'h0;
        mval[d][i] = 1'b0;
      end
    end
    test_reset();
    test_basic();
    test_both_high();
    test_back_to_back(0, 32'h10);
    test_back_to_back(1, 32'h04);
    test_scramble();
    test_reset_mid();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
